// File: rtl/bcd_entry_to_binary_if.sv
// Switch/key inputs and display/result outputs of the two-digit BCD entry block.
interface bcd_entry_to_binary_if;
   logic [3:0] SW;
   logic       Enter;
   logic       Clear;
   logic [0:6] HEX1;
   logic [0:6] HEX0;
   logic [6:0] Value;
   logic       Valid;
   logic       Error;

   modport master (
      output SW, Enter, Clear,
      input  HEX1, HEX0, Value, Valid, Error
   );

   modport slave (
      input  SW, Enter, Clear,
      output HEX1, HEX0, Value, Valid, Error
   );
endinterface

// File: rtl/bcd_entry_to_binary.sv
// Two-digit BCD keypad entry: echoes digits on active-low 7-segment displays and
// converts the completed entry to a 7-bit binary value.
module bcd_entry_to_binary #(
   parameter bit SHOW_LEADING_ZERO = 1'b1
) (
   input logic                  Clock,
   input logic                  Reset,
   bcd_entry_to_binary_if.slave bus
);

   typedef enum logic [1:0] {S_TENS, S_ONES, S_DONE, S_ERR} state_t;

   localparam logic [0:6] SEG_BLANK = 7'b1111111;
   localparam logic [0:6] SEG_E     = 7'b0110000;

   state_t     state;
   logic [3:0] tens;
   logic [3:0] ones;
   logic [6:0] value;
   logic       valid;
   logic       error;
   logic [0:6] hex1;
   logic [0:6] hex0;
   logic       enter_q;
   logic       press;
   logic       legal;
   logic [6:0] tens_wide;

   function automatic logic [0:6] seg(input logic [3:0] d);
      logic [0:6] p;
      case (d)
         4'd0:    p = 7'b0000001;
         4'd1:    p = 7'b1001111;
         4'd2:    p = 7'b0010010;
         4'd3:    p = 7'b0000110;
         4'd4:    p = 7'b1001100;
         4'd5:    p = 7'b0100100;
         4'd6:    p = 7'b0100000;
         4'd7:    p = 7'b0001111;
         4'd8:    p = 7'b0000000;
         4'd9:    p = 7'b0000100;
         default: p = SEG_BLANK;
      endcase
      return p;
   endfunction

   assign press     = bus.Enter & ~enter_q;
   assign legal     = (bus.SW <= 4'd9);
   assign tens_wide = {3'b000, tens};

   always_ff @(posedge Clock) begin
      if (Reset) begin
         // enter_q starts high so a key held through reset is not a press.
         enter_q <= 1'b1;
         state   <= S_TENS;
         tens    <= 4'd0;
         ones    <= 4'd0;
         value   <= 7'd0;
         valid   <= 1'b0;
         error   <= 1'b0;
         hex1    <= SEG_BLANK;
         hex0    <= SEG_BLANK;
      end else begin
         enter_q <= bus.Enter;
         if (bus.Clear) begin
            state <= S_TENS;
            tens  <= 4'd0;
            ones  <= 4'd0;
            value <= 7'd0;
            valid <= 1'b0;
            error <= 1'b0;
            hex1  <= SEG_BLANK;
            hex0  <= SEG_BLANK;
         end else if (press && state != S_ERR) begin
            if (!legal) begin
               state <= S_ERR;
               error <= 1'b1;
               valid <= 1'b0;
               hex1  <= SEG_E;
               hex0  <= SEG_E;
            end else begin
               unique case (state)
                  S_TENS, S_DONE: begin
                     // In S_DONE a new digit starts a fresh entry; Value is kept.
                     state <= S_ONES;
                     tens  <= bus.SW;
                     ones  <= 4'd0;
                     valid <= 1'b0;
                     hex1  <= seg(bus.SW);
                     hex0  <= SEG_BLANK;
                  end
                  S_ONES: begin
                     state <= S_DONE;
                     ones  <= bus.SW;
                     value <= (tens_wide << 3) + (tens_wide << 1) + {3'b000, bus.SW};
                     valid <= 1'b1;
                     hex1  <= (SHOW_LEADING_ZERO || tens != 4'd0) ? seg(tens) : SEG_BLANK;
                     hex0  <= seg(bus.SW);
                  end
                  S_ERR: begin
                     state <= S_ERR;
                  end
               endcase
            end
         end
      end
   end

   assign bus.HEX1  = hex1;
   assign bus.HEX0  = hex0;
   assign bus.Value = value;
   assign bus.Valid = valid;
   assign bus.Error = error;

endmodule

// File: tb/tb_bcd_entry_to_binary.sv
// Directed plus random bench for bcd_entry_to_binary; both leading-zero variants run in
// lockstep against an arithmetic reference model.
module tb_bcd_entry_to_binary;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bcd_entry_to_binary_if if_lz ();
   bcd_entry_to_binary_if if_nz ();

   bcd_entry_to_binary #(.SHOW_LEADING_ZERO(1'b1)) dut_lz (
      .Clock (clk),
      .Reset (rst),
      .bus   (if_lz.slave)
   );

   bcd_entry_to_binary #(.SHOW_LEADING_ZERO(1'b0)) dut_nz (
      .Clock (clk),
      .Reset (rst),
      .bus   (if_nz.slave)
   );

   localparam logic [0:6] PAT [10] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
      7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
   };
   localparam logic [0:6] BLANK = 7'b1111111;
   localparam logic [0:6] ECHR  = 7'b0110000;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: phase 0 = waiting tens, 1 = waiting ones, 2 = done, 3 = error.
   int m_phase, m_tens, m_ones, m_value;
   bit m_valid, m_error, m_prev_enter;

   function automatic logic [0:6] want_hex1(input bit lz);
      case (m_phase)
         1:       return PAT[m_tens];
         2:       return (lz || m_tens != 0) ? PAT[m_tens] : BLANK;
         3:       return ECHR;
         default: return BLANK;
      endcase
   endfunction

   function automatic logic [0:6] want_hex0();
      case (m_phase)
         2:       return PAT[m_ones];
         3:       return ECHR;
         default: return BLANK;
      endcase
   endfunction

   task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_phase = 0;
      m_tens  = 0;
      m_ones  = 0;
      m_value = 0;
      m_valid = 0;
      m_error = 0;
   endtask

   task automatic model_edge(input int sw, input bit en, input bit clr, input bit rs);
      bit press;
      if (rs) begin
         model_clear();
         m_prev_enter = 1;
      end else begin
         press = en && !m_prev_enter;
         m_prev_enter = en;
         if (clr) model_clear();
         else if (press && m_phase != 3) begin
            if (sw > 9) begin
               m_phase = 3;
               m_error = 1;
               m_valid = 0;
            end else if (m_phase == 1) begin
               m_ones  = sw;
               m_value = m_tens * 10 + sw;
               m_valid = 1;
               m_phase = 2;
            end else begin
               m_tens  = sw;
               m_ones  = 0;
               m_valid = 0;
               m_phase = 1;
            end
         end
      end
   endtask

   task automatic check_all();
      check("lz_value", if_lz.Value, 7'(m_value));
      check("lz_valid", {6'd0, if_lz.Valid}, {6'd0, m_valid});
      check("lz_error", {6'd0, if_lz.Error}, {6'd0, m_error});
      check("lz_hex1", if_lz.HEX1, want_hex1(1'b1));
      check("lz_hex0", if_lz.HEX0, want_hex0());
      check("nz_value", if_nz.Value, 7'(m_value));
      check("nz_valid", {6'd0, if_nz.Valid}, {6'd0, m_valid});
      check("nz_error", {6'd0, if_nz.Error}, {6'd0, m_error});
      check("nz_hex1", if_nz.HEX1, want_hex1(1'b0));
      check("nz_hex0", if_nz.HEX0, want_hex0());
   endtask

   // Drive inputs, take one rising edge, then compare just after it.
   task automatic cyc(input int sw, input bit en, input bit clr, input bit rs);
      if_lz.SW = 4'(sw); if_lz.Enter = en; if_lz.Clear = clr;
      if_nz.SW = 4'(sw); if_nz.Enter = en; if_nz.Clear = clr;
      rst = rs;
      @(posedge clk);
      model_edge(sw, en, clr, rs);
      #1;
      check_all();
   endtask

   task automatic key(input int sw);
      cyc(sw, 1'b1, 1'b0, 1'b0);
      cyc(sw, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      model_clear();
      m_prev_enter = 1;
      if_lz.SW = '0; if_lz.Enter = 1'b1; if_lz.Clear = 1'b0;
      if_nz.SW = '0; if_nz.Enter = 1'b1; if_nz.Clear = 1'b0;

      // Enter held through reset release must not register a press.
      cyc(3, 1, 0, 1);
      cyc(3, 1, 0, 1);
      cyc(3, 1, 0, 0);
      cyc(3, 1, 0, 0);
      cyc(3, 0, 0, 0);

      key(4);
      check("tens4_hex1", if_lz.HEX1, 7'b1001100);
      key(2);
      check("value42", if_lz.Value, 7'b0101010);
      check("hex0_2", if_lz.HEX0, 7'b0010010);

      cyc(0, 0, 1, 0);
      for (int i = 0; i < 20; i++) cyc(7, 1, 0, 0);
      cyc(7, 0, 0, 0);
      check("held7_hex1", if_lz.HEX1, 7'b0001111);

      cyc(0, 0, 1, 0);
      key(9);
      key(9);
      check("value99", if_lz.Value, 7'd99);
      key(0);
      check("new_tens0", if_nz.HEX1, 7'b0000001);
      key(5);
      check("value5", if_lz.Value, 7'd5);
      check("nz_blank_tens", if_nz.HEX1, 7'b1111111);

      cyc(0, 0, 1, 0);
      key(12);
      check("err_flag", {6'd0, if_lz.Error}, 7'd1);
      for (int i = 0; i < 3; i++) key(3);
      cyc(3, 0, 1, 0);
      check("clr_value", if_lz.Value, 7'd0);

      key(6);
      cyc(1, 1, 1, 0);
      cyc(1, 0, 0, 0);
      key(8);
      cyc(8, 0, 0, 1);
      cyc(8, 0, 0, 0);

      for (int i = 0; i < 600; i++) begin
         int sw;
         bit en, clr, rs;
         sw  = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
         en  = $urandom_range(0, 1);
         clr = ($urandom_range(0, 24) == 0);
         rs  = ($urandom_range(0, 59) == 0);
         cyc(sw, en, clr, rs);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
